// File: rtl/hall_rpm_counter.sv
// Hall sensor pulse counter: sync, debounce, gated edge count and
// sequential conversion of the captured count to RPM.
module hall_rpm_counter #(
  parameter int CNT_W      = 16,
  parameter int RPM_W      = 20,
  parameter int PPR        = 2,
  parameter int GATE_SEC   = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hall_in,
  input  logic             count_en,
  input  logic             done,
  output logic [RPM_W-1:0] rpm,
  output logic             rpm_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int NUM_W = CNT_W + 6;
  localparam int D     = PPR * GATE_SEC;
  localparam int REM_W = $clog2(D + 1);
  localparam int IDX_W = $clog2(NUM_W);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int WW    = (NUM_W > RPM_W) ? NUM_W : RPM_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RPM_W-1:0] RPM_MAX = '1;

  logic             s1;
  logic             hall_s;
  logic             hall_clean;
  logic             hall_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic             pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      hall_s     <= 1'b0;
      hall_clean <= 1'b0;
      hall_prev  <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      s1        <= hall_in;
      hall_s    <= s1;
      hall_prev <= hall_clean;
      if (hall_s == hall_clean) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        hall_clean <= hall_s;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign pulse = hall_clean & ~hall_prev;

  logic             en_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ovf;

  // A fresh window restarts the count, including a pulse on that same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d    <= 1'b0;
      cnt     <= '0;
      cnt_ovf <= 1'b0;
    end else begin
      en_d <= count_en;
      if (count_en && !en_d) begin
        cnt     <= pulse ? CNT_W'(1) : '0;
        cnt_ovf <= 1'b0;
      end else if (count_en && pulse) begin
        if (cnt == CNT_MAX) cnt_ovf <= 1'b1;
        else                cnt     <= cnt + 1'b1;
      end
    end
  end

  logic [1:0]       state;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] quo;
  logic [REM_W-1:0] rem;
  logic [IDX_W-1:0] idx;
  logic             ovf_cap;
  logic [REM_W:0]   cand;
  logic             ge;
  logic [WW-1:0]    q_ext;
  logic [RPM_W-1:0] rpm_sat;

  assign cand    = {rem, num[idx]};
  assign ge      = cand >= (REM_W + 1)'(D);
  assign q_ext   = WW'(quo);
  assign rpm_sat = (q_ext > WW'(RPM_MAX)) ? RPM_MAX : q_ext[RPM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      num       <= '0;
      quo       <= '0;
      rem       <= '0;
      idx       <= '0;
      ovf_cap   <= 1'b0;
      rpm       <= '0;
      rpm_valid <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rpm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (done) begin
            num     <= NUM_W'(cnt) * NUM_W'(60);
            ovf_cap <= cnt_ovf;
            idx     <= IDX_W'(NUM_W - 1);
            rem     <= '0;
            quo     <= '0;
            busy    <= 1'b1;
            state   <= DIV;
          end
        end
        DIV: begin
          rem <= ge ? REM_W'(cand - (REM_W + 1)'(D))
                    : cand[REM_W-1:0];
          quo <= {quo[NUM_W-2:0], ge};
          idx <= idx - 1'b1;
          if (idx == '0) state <= OUT;
        end
        OUT: begin
          rpm       <= rpm_sat;
          overflow  <= ovf_cap;
          rpm_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hall_rpm_counter.sv
// Bench for hall_rpm_counter: a default instance and a CNT_W=4
// instance share the stimulus and are checked against count arithmetic.
module tb_hall_rpm_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hall_in;
  logic        count_en;
  logic        done;
  logic [19:0] rpm_a;
  logic        rpm_valid_a;
  logic        ovf_a;
  logic        busy_a;
  logic [19:0] rpm_b;
  logic        rpm_valid_b;
  logic        ovf_b;
  logic        busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hall_rpm_counter u_a (
    .clk       (clk),
    .rst       (rst),
    .hall_in   (hall_in),
    .count_en  (count_en),
    .done      (done),
    .rpm       (rpm_a),
    .rpm_valid (rpm_valid_a),
    .overflow  (ovf_a),
    .busy      (busy_a)
  );

  hall_rpm_counter #(.CNT_W(4)) u_b (
    .clk       (clk),
    .rst       (rst),
    .hall_in   (hall_in),
    .count_en  (count_en),
    .done      (done),
    .rpm       (rpm_b),
    .rpm_valid (rpm_valid_b),
    .overflow  (ovf_b),
    .busy      (busy_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: saturate the true pulse count, then rpm = count*60/(PPR*GATE)
  function automatic int exp_rpm(input int n, input int cw);
    int mx;
    int c;
    int r;
    mx = (1 << cw) - 1;
    c  = (n > mx) ? mx : n;
    r  = (c * 60) / 2;
    return (r > 1048575) ? 1048575 : r;
  endfunction

  function automatic int exp_ovf(input int n, input int cw);
    return (n > (1 << cw) - 1) ? 1 : 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_hi(input int hi, input int lo);
    hall_in = 1'b1;
    tick(hi);
    hall_in = 1'b0;
    tick(lo);
  endtask

  task automatic run_window(input int np, input int ng);
    int p;
    int g;
    p = np;
    g = ng;
    count_en = 1'b1;
    tick(3);
    while (p + g > 0) begin
      if (g > 0 && (p == 0 || $urandom_range(0, 1) == 1)) begin
        pulse_hi($urandom_range(1, 3), $urandom_range(6, 12));
        g--;
      end else begin
        pulse_hi($urandom_range(6, 15), $urandom_range(6, 15));
        p--;
      end
    end
    tick(12);
  endtask

  task automatic close_and_check(input string tag, input int n,
                                 input int redone_at);
    int va;
    int vb;
    int la;
    int lb;
    va = 0;
    vb = 0;
    la = 0;
    lb = 0;
    count_en = 1'b0;
    done     = 1'b1;
    tick(1);
    done = 1'b0;
    chk({tag, ".busy"}, busy_a, 1);
    for (int i = 1; i <= 60; i++) begin
      if (rpm_valid_a) begin
        va++;
        if (la == 0) la = i;
      end
      if (rpm_valid_b) begin
        vb++;
        if (lb == 0) lb = i;
      end
      done = (i == redone_at);
      tick(1);
    end
    done = 1'b0;
    chk({tag, ".valid_a_cnt"}, va, 1);
    chk({tag, ".lat_a"}, la, 24);
    chk({tag, ".valid_b_cnt"}, vb, 1);
    chk({tag, ".lat_b"}, lb, 12);
    chk({tag, ".rpm_a"}, rpm_a, exp_rpm(n, 16));
    chk({tag, ".ovf_a"}, ovf_a, exp_ovf(n, 16));
    chk({tag, ".rpm_b"}, rpm_b, exp_rpm(n, 4));
    chk({tag, ".ovf_b"}, ovf_b, exp_ovf(n, 4));
    chk({tag, ".idle"}, busy_a, 0);
  endtask

  initial begin
    int va;
    int vb;
    int n;
    int g;
    rst      = 1'b1;
    hall_in  = 1'b0;
    count_en = 1'b0;
    done     = 1'b0;
    tick(3);
    chk("rst.rpm_a", rpm_a, 0);
    chk("rst.valid_a", rpm_valid_a, 0);
    chk("rst.ovf_a", ovf_a, 0);
    chk("rst.busy_a", busy_a, 0);
    chk("rst.rpm_b", rpm_b, 0);
    chk("rst.busy_b", busy_b, 0);
    rst = 1'b0;
    tick(3);

    run_window(10, 0);
    close_and_check("w10", 10, 0);

    run_window(6, 5);
    close_and_check("glitch", 6, 0);

    count_en = 1'b0;
    repeat (3) pulse_hi(10, 10);
    run_window(2, 0);
    close_and_check("gated", 2, 0);

    run_window(20, 0);
    close_and_check("sat", 20, 0);
    run_window(3, 0);
    close_and_check("after_sat", 3, 0);

    run_window(5, 0);
    close_and_check("b2b1", 5, 0);
    // Edge lands on the same clock as the window opening
    hall_in = 1'b1;
    tick(6);
    count_en = 1'b1;
    tick(6);
    hall_in = 1'b0;
    tick(10);
    pulse_hi(10, 10);
    tick(12);
    close_and_check("b2b2", 2, 0);

    run_window(3, 0);
    count_en = 1'b0;
    done     = 1'b1;
    tick(1);
    done = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    va = 0;
    vb = 0;
    for (int i = 0; i < 40; i++) begin
      if (rpm_valid_a) va++;
      if (rpm_valid_b) vb++;
      tick(1);
    end
    chk("abort.valid_a", va, 0);
    chk("abort.valid_b", vb, 0);
    chk("abort.rpm_a", rpm_a, 0);
    chk("abort.busy_a", busy_a, 0);
    chk("abort.ovf_b", ovf_b, 0);
    run_window(4, 0);
    close_and_check("post_rst", 4, 0);

    run_window(7, 1);
    close_and_check("redone", 7, 5);

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(0, 22);
      g = $urandom_range(0, 4);
      run_window(n, g);
      close_and_check($sformatf("rnd%0d", k), n, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
